// File: rtl/mem_port_arbiter.sv
// Two-port word arbiter over a byte-wide, synchronous-read memory; each word access is four little-endian byte beats.
// Optional macro MEM_ARB_RR_EN selects round-robin arbitration; otherwise port 1 has fixed priority.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RR_INIT    = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [31:0]           p0_addr,
  input  logic [31:0]           p0_wdata,
  input  logic [3:0]            p0_be,
  output logic                  p0_ack,
  output logic [31:0]           p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [31:0]           p1_addr,
  input  logic [31:0]           p1_wdata,
  input  logic [3:0]            p1_be,
  output logic                  p1_ack,
  output logic [31:0]           p1_rdata,
  output logic                  m_en,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [7:0]            m_wdata,
  input  logic [7:0]            m_rdata
);

  typedef enum logic [1:0] {IDLE, BEAT, TAIL, DONE} state_t;

  localparam int unsigned WAW = ADDR_WIDTH - 2;

  state_t         state_q;
  logic [1:0]     beat_q;
  logic [1:0]     beat_d;
  logic [1:0]     beat_prev;
  logic           win_q;
  logic           win_d;
  logic           we_l_q;
  logic [WAW-1:0] addr_l_q;
  logic [31:0]    wdata_l_q;
  logic [3:0]     be_l_q;
  logic [23:0]    rbuf_q;
`ifdef MEM_ARB_RR_EN
  logic           prio_q;
`endif

  logic           sel_we;
  logic [WAW-1:0] sel_addr;
  logic [31:0]    sel_wdata;
  logic [3:0]     sel_be;

  // Byte offset bits and bits above the memory size are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{p0_addr[31:ADDR_WIDTH], p0_addr[1:0],
                         p1_addr[31:ADDR_WIDTH], p1_addr[1:0], (RR_INIT != 0)};

  always_comb begin
    beat_d    = beat_q + 2'd1;
    beat_prev = beat_q - 2'd1;
`ifdef MEM_ARB_RR_EN
    win_d     = (p0_req && p1_req) ? prio_q : p1_req;
`else
    win_d     = p1_req;
`endif
    sel_we    = win_d ? p1_we                    : p0_we;
    sel_addr  = win_d ? p1_addr[ADDR_WIDTH-1:2]  : p0_addr[ADDR_WIDTH-1:2];
    sel_wdata = win_d ? p1_wdata                 : p0_wdata;
    sel_be    = win_d ? p1_be                    : p0_be;
  end

  // Memory strobes are registered one state ahead so they line up with BEAT cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      win_q     <= 1'b0;
      we_l_q    <= 1'b0;
      addr_l_q  <= '0;
      wdata_l_q <= '0;
      be_l_q    <= '0;
      rbuf_q    <= '0;
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
      m_en      <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
`ifdef MEM_ARB_RR_EN
      prio_q    <= (RR_INIT != 0);
`endif
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (p0_req || p1_req) begin
            state_q   <= BEAT;
            beat_q    <= '0;
            win_q     <= win_d;
            we_l_q    <= sel_we;
            addr_l_q  <= sel_addr;
            wdata_l_q <= sel_wdata;
            be_l_q    <= sel_be;
            m_en      <= 1'b1;
            m_we      <= sel_we & sel_be[0];
            m_addr    <= {sel_addr, 2'b00};
            m_wdata   <= sel_wdata[7:0];
`ifdef MEM_ARB_RR_EN
            prio_q    <= ~prio_q;
`endif
          end
        end
        BEAT: begin
          // Read data lags the strobe by one cycle, so beat n captures byte n-1.
          if (!we_l_q && beat_q != 2'd0) begin
            rbuf_q[{beat_prev, 3'b000} +: 8] <= m_rdata;
          end
          if (beat_q == 2'd3) begin
            state_q <= TAIL;
            beat_q  <= '0;
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
          end else begin
            beat_q  <= beat_d;
            m_addr  <= {addr_l_q, beat_d};
            m_we    <= we_l_q & be_l_q[beat_d];
            m_wdata <= wdata_l_q[{beat_d, 3'b000} +: 8];
          end
        end
        TAIL: begin
          state_q <= DONE;
          if (win_q) p1_ack <= 1'b1;
          else       p0_ack <= 1'b1;
          if (!we_l_q) begin
            if (win_q) p1_rdata <= {m_rdata, rbuf_q};
            else       p0_rdata <= {m_rdata, rbuf_q};
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand sequences and randomized rounds vs a reference model.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 10;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  typedef struct {
    int          port;
    req_t        r;
    logic [31:0] exp_rd;
    logic [9:0]  exp_a0;
  } vec_t;

  typedef struct packed {
    logic [9:0] a;
    logic       we;
    logic [7:0] d;
  } beat_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          p0_req = 1'b0, p0_we = 1'b0;
  logic [31:0]   p0_addr = '0, p0_wdata = '0;
  logic [3:0]    p0_be = '0;
  logic          p0_ack;
  logic [31:0]   p0_rdata;
  logic          p1_req = 1'b0, p1_we = 1'b0;
  logic [31:0]   p1_addr = '0, p1_wdata = '0;
  logic [3:0]    p1_be = '0;
  logic          p1_ack;
  logic [31:0]   p1_rdata;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_wdata;
  logic [7:0]    m_rdata;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .RR_INIT(0)) dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clock = ~clock;

  // Byte-wide synchronous-read memory.
  logic [7:0] mem [0:1023];
  always @(posedge clock) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata <= mem[m_addr];
    end
  end

  beat_t trace[$];
  always @(negedge clock) begin
    if (m_en) trace.push_back({m_addr, m_we, m_wdata});
  end

  // Reference model: flat byte array, last read word per port, priority bit.
  logic [7:0]  mmem [0:1023];
  logic [31:0] last_rd [2];
`ifdef MEM_ARB_RR_EN
  bit          model_prio = 1'b0;
`endif

  function automatic int model_pick(input logic [1:0] en);
    if (en == 2'b11) begin
`ifdef MEM_ARB_RR_EN
      return int'(model_prio);
`else
      return 1;
`endif
    end
    return en[1] ? 1 : 0;
  endfunction

  function automatic void model_granted();
`ifdef MEM_ARB_RR_EN
    model_prio = ~model_prio;
`endif
  endfunction

  function automatic int unsigned word_base(input logic [31:0] addr);
    return (int'(addr % 1024) / 4) * 4;
  endfunction

  function automatic logic [31:0] model_apply(input int p, input logic we, input logic [31:0] addr,
                                              input logic [31:0] wd, input logic [3:0] be);
    int unsigned base = word_base(addr);
    logic [31:0] w;
    if (we) begin
      for (int i = 0; i < 4; i++) if (be[i]) mmem[base + i] = wd[8*i +: 8];
      return last_rd[p];
    end
    for (int i = 0; i < 4; i++) w[8*i +: 8] = mmem[base + i];
    last_rd[p] = w;
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int p, input req_t r, input logic req);
    if (p == 0) begin
      p0_we = r.we; p0_addr = r.addr; p0_wdata = r.wdata; p0_be = r.be; p0_req = req;
    end else begin
      p1_we = r.we; p1_addr = r.addr; p1_wdata = r.wdata; p1_be = r.be; p1_req = req;
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.we    = 1'($urandom_range(0, 1));
    r.addr  = $urandom() & 32'hFFFF_F23F;
    r.wdata = $urandom();
    r.be    = 4'($urandom_range(0, 15));
    return r;
  endfunction

  // One round: raise the enabled requests together, serve them to completion, check against the model.
  task automatic run_round(input logic [1:0] en, input req_t r0, input req_t r1,
                           output logic [31:0] rd0, output logic [31:0] rd1);
    int          exp_order[$];
    int          got_p[$];
    int          got_k[$];
    logic [31:0] got_rd[$];
    logic [1:0]  pending;
    int          first;
    int          j;
    req_t        r;
    logic [31:0] exp_rd;
    rd0 = '0;
    rd1 = '0;
    trace.delete();
    @(posedge clock); #1;
    drive(0, r0, en[0]);
    drive(1, r1, en[1]);
    first = model_pick(en);
    exp_order.push_back(first);
    if (en == 2'b11) exp_order.push_back(1 - first);
    pending = en;
    for (int k = 1; k <= 40 && pending != 2'b00; k++) begin
      @(negedge clock);
      if (p0_ack) begin
        got_p.push_back(0); got_k.push_back(k); got_rd.push_back(p0_rdata);
        rd0 = p0_rdata; p0_req = 1'b0; pending[0] = 1'b0;
      end
      if (p1_ack) begin
        got_p.push_back(1); got_k.push_back(k); got_rd.push_back(p1_rdata);
        rd1 = p1_rdata; p1_req = 1'b0; pending[1] = 1'b0;
      end
    end
    chk("ack_count", got_p.size(), exp_order.size());
    j = 0;
    foreach (exp_order[i]) begin
      r = (exp_order[i] == 1) ? r1 : r0;
      exp_rd = model_apply(exp_order[i], r.we, r.addr, r.wdata, r.be);
      model_granted();
      if (i < got_p.size()) begin
        chk("grant_port", got_p[i], exp_order[i]);
        chk("ack_latency", got_k[i], 7 + 7 * i);
        chk("rdata", got_rd[i], exp_rd);
      end
      for (int b = 0; b < 4; b++) begin
        if (j < trace.size()) begin
          chk("beat", {trace[j].a, trace[j].we, trace[j].we ? trace[j].d : 8'h00},
              {10'(word_base(r.addr) + b), r.we & r.be[b], (r.we & r.be[b]) ? r.wdata[8*b +: 8] : 8'h00});
        end
        j++;
      end
    end
    chk("beat_count", trace.size(), 4 * exp_order.size());
  endtask

  vec_t        tbl[11];
  req_t        idle_r = '{1'b0, 32'h0, 32'h0, 4'h0};
  logic [31:0] rd0, rd1, a0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1, '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF}, 32'h0,        10'h010};
    tbl[1]  = '{0, '{1'b0, 32'h0000_0010, 32'h0,        4'hF}, 32'hDEADBEEF, 10'h010};
    tbl[2]  = '{1, '{1'b1, 32'h0000_0020, 32'hAAAAAAAA, 4'hF}, 32'h0,        10'h020};
    tbl[3]  = '{0, '{1'b1, 32'h0000_0020, 32'h11223344, 4'h5}, 32'h0,        10'h020};
    tbl[4]  = '{0, '{1'b0, 32'h0000_0020, 32'h0,        4'hF}, 32'hAA22AA44, 10'h020};
    tbl[5]  = '{1, '{1'b1, 32'h0000_0020, 32'hFFFFFFFF, 4'h0}, 32'h0,        10'h020};
    tbl[6]  = '{1, '{1'b0, 32'h0000_0023, 32'h0,        4'hF}, 32'hAA22AA44, 10'h020};
    tbl[7]  = '{1, '{1'b1, 32'h0000_03FE, 32'hCAFEF00D, 4'hF}, 32'h0,        10'h3FC};
    tbl[8]  = '{1, '{1'b1, 32'h8000_0000, 32'h01020304, 4'hF}, 32'h0,        10'h000};
    tbl[9]  = '{0, '{1'b0, 32'h0000_03FE, 32'h0,        4'hF}, 32'hCAFEF00D, 10'h3FC};
    tbl[10] = '{0, '{1'b0, 32'h0000_0400, 32'h0,        4'hF}, 32'h01020304, 10'h000};
    last_rd[0] = '0;
    last_rd[1] = '0;

    // Reset state.
    repeat (3) @(negedge clock);
    chk("rst_m_en", m_en, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_acks", {p0_ack, p1_ack}, 0);
    chk("rst_rdata", p0_rdata | p1_rdata, 0);
    reset = 1'b1;

    // Loader preloads every word the random rounds can touch.
    for (int w = 0; w < 144; w++) begin
      run_round(2'b10, idle_r, '{1'b1, 32'(w * 4), $urandom(), 4'hF}, rd0, rd1);
    end

    // Directed vectors.
    for (int i = 0; i < 11; i++) begin
      run_round(tbl[i].port == 1 ? 2'b10 : 2'b01,
                tbl[i].port == 1 ? idle_r : tbl[i].r,
                tbl[i].port == 1 ? tbl[i].r : idle_r, rd0, rd1);
      if (!tbl[i].r.we) chk("tbl_rdata", tbl[i].port == 1 ? rd1 : rd0, tbl[i].exp_rd);
      a0 = (trace.size() > 0) ? {22'd0, trace[0].a} : 32'hFFFF_FFFF;
      chk("tbl_addr0", a0, {22'd0, tbl[i].exp_a0});
    end

    // Both ports held high; each winner re-requests immediately after its ack.
    begin
      int          g[$];
      int          gk[$];
      int          e;
      logic [31:0] r;
      @(posedge clock); #1;
      drive(0, '{1'b0, 32'h10, 32'h0, 4'hF}, 1'b1);
      drive(1, '{1'b0, 32'h20, 32'h0, 4'hF}, 1'b1);
      for (int k = 1; k <= 80 && g.size() < 4; k++) begin
        @(negedge clock);
        if (p0_ack || p1_ack) begin
          int p;
          p = p1_ack ? 1 : 0;
          g.push_back(p);
          gk.push_back(k);
          r = (p == 1) ? p1_rdata : p0_rdata;
          chk("arb_rdata", r, model_apply(p, 1'b0, (p == 1) ? 32'h20 : 32'h10, 32'h0, 4'hF));
          if (p == 1) p1_req = 1'b0; else p0_req = 1'b0;
          if (g.size() < 3) begin
            @(posedge clock); #1;
            if (p == 1) p1_req = 1'b1; else p0_req = 1'b1;
          end
        end
      end
      chk("arb_count", g.size(), 4);
      e = 0;
      for (int i = 0; i < 4; i++) begin
        e = (i < 3) ? model_pick(2'b11) : 1 - e;
        model_granted();
        if (i < g.size()) begin
          chk("arb_grant", g[i], e);
          chk("arb_spacing", gk[i], 7 + 7 * i);
        end
      end
    end

    // Request dropped and payload changed after grant.
    begin
      int acks;
      int ack_k;
      acks = 0;
      ack_k = 0;
      trace.delete();
      @(posedge clock); #1;
      drive(0, '{1'b1, 32'h80, 32'h0BADF00D, 4'hF}, 1'b1);
      for (int k = 1; k <= 20; k++) begin
        @(negedge clock);
        if (k == 3) drive(0, '{1'b1, 32'h84, 32'hFFFFFFFF, 4'h0}, 1'b0);
        if (p0_ack || p1_ack) begin
          acks++;
          ack_k = k;
        end
      end
      chk("drop_acks", acks, 1);
      chk("drop_ack_lat", ack_k, 7);
      chk("drop_beats", trace.size(), 4);
      foreach (trace[j]) chk("drop_beat", {trace[j].a, trace[j].we}, {10'(32'h80 + j), 1'b1});
      void'(model_apply(0, 1'b1, 32'h80, 32'h0BADF00D, 4'hF));
      run_round(2'b10, idle_r, '{1'b0, 32'h80, 32'h0, 4'hF}, rd0, rd1);
      chk("drop_readback", rd1, 32'h0BADF00D);
      run_round(2'b01, '{1'b0, 32'h84, 32'h0, 4'hF}, idle_r, rd0, rd1);
    end

    // Reset during beat 2 of a write.
    begin
      int acks;
      int ens;
      run_round(2'b10, idle_r, '{1'b1, 32'h40, 32'h11111111, 4'hF}, rd0, rd1);
      @(posedge clock); #1;
      drive(0, '{1'b1, 32'h40, 32'h55667788, 4'hF}, 1'b1);
      repeat (4) @(negedge clock);
      chk("rst_pre_addr", m_addr, 32'h42);
      reset = 1'b0;
      #1;
      p0_req = 1'b0;
      chk("rst_mid_m_en", m_en, 0);
      chk("rst_mid_m_we", m_we, 0);
      chk("rst_mid_m_addr", m_addr, 0);
      chk("rst_mid_m_wdata", m_wdata, 0);
      chk("rst_mid_acks", {p0_ack, p1_ack}, 0);
      chk("rst_mid_p0_rdata", p0_rdata, 0);
      chk("rst_mid_p1_rdata", p1_rdata, 0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      acks = 0;
      ens = 0;
      repeat (10) begin
        @(negedge clock);
        if (p0_ack || p1_ack) acks++;
        if (m_en) ens++;
      end
      chk("rst_post_acks", acks, 0);
      chk("rst_post_m_en", ens, 0);
      mmem[32'h40] = 8'h88;
      mmem[32'h41] = 8'h77;
      last_rd[0] = '0;
      last_rd[1] = '0;
`ifdef MEM_ARB_RR_EN
      model_prio = 1'b0;
`endif
      run_round(2'b10, idle_r, '{1'b0, 32'h40, 32'h0, 4'hF}, rd0, rd1);
      chk("rst_partial_word", rd1, 32'h11117788);
    end

    // Randomized rounds against the model.
    for (int n = 0; n < 60; n++) begin
      run_round(2'($urandom_range(1, 3)), rand_req(), rand_req(), rd0, rd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
